// File: rtl/cobra_pkg.sv
// Shared definitions for the cobra core: fetch FSM states, instruction
// field positions, the halt word and the ALU opcodes used by the execute stage.
package cobra_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam int J_BIT     = 31;
   localparam int B_BIT     = 30;
   localparam int WS_HI     = 29;
   localparam int WS_LO     = 28;
   localparam int CONST_HI  = 27;
   localparam int CONST_LO  = 5;
   localparam int ALU_HI    = 26;
   localparam int ALU_LO    = 23;
   localparam int RA1_HI    = 22;
   localparam int RA1_LO    = 18;
   localparam int RA2_HI    = 17;
   localparam int RA2_LO    = 13;
   localparam int OFF_LO    = 5;
   localparam int WA_HI     = 4;
   localparam int WA_LO     = 0;

   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;
   localparam logic [3:0] ALU_EQ   = 4'd10;
   localparam logic [3:0] ALU_NE   = 4'd11;
   localparam logic [3:0] ALU_LT   = 4'd12;
   localparam logic [3:0] ALU_GE   = 4'd13;
   localparam logic [3:0] ALU_LTU  = 4'd14;
   localparam logic [3:0] ALU_GEU  = 4'd15;

endpackage

// File: rtl/cobra_next_pc.sv
// Next-PC selection: word-offset jump/branch target or sequential PC + 4.
// All arithmetic wraps modulo 2^32.
module cobra_next_pc
   import cobra_pkg::*;
#(
   parameter int OFFSET_W = 8
) (
   input  logic [31:0]         pc,
   input  logic [OFFSET_W-1:0] offset,
   input  logic                j,
   input  logic                b,
   input  logic                c,
   output logic [31:0]         next_pc
);

   logic [31:0] off_bytes;
   logic        taken;

   // Word offset sign-extended and scaled to bytes.
   assign off_bytes = {{(30-OFFSET_W){offset[OFFSET_W-1]}}, offset, 2'b00};
   assign taken     = j | (b & c);
   assign next_pc   = taken ? (pc + off_bytes) : (pc + 32'd4);

endmodule

// File: rtl/cobra_fetch_ctrl.sv
// Fetch/sequencing stage: owns PC and IR, fetches one instruction at a time
// and drives decoded control fields to the execute datapath.
//
// state    | meaning
// ST_FETCH | one-cycle mem_req with mem_addr = PC
// ST_WAIT  | wait for mem_valid; latch IR or enter halt
// ST_EXEC  | decoded fields live, we_rf active, PC updated from C
// ST_HALT  | absorbing; only rst leaves
module cobra_fetch_ctrl
   import cobra_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          OFFSET_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_valid,
   output logic [3:0]  Upr_ALU,
   output logic [1:0]  WS,
   output logic [4:0]  RA1,
   output logic [4:0]  RA2,
   output logic [4:0]  WA,
   output logic [31:0] Const,
   output logic        we_rf,
   input  logic        C,
   output logic [31:0] PC,
   output logic        halted
);

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] ir;
   logic [31:0] next_pc;
   logic        req_q;
   logic        we_q;

   cobra_next_pc #(.OFFSET_W(OFFSET_W)) u_next_pc (
      .pc      (pc_q),
      .offset  (ir[OFF_LO +: OFFSET_W]),
      .j       (ir[J_BIT]),
      .b       (ir[B_BIT]),
      .c       (C),
      .next_pc (next_pc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_FETCH;
         pc_q   <= RESET_PC;
         ir     <= '0;
         req_q  <= 1'b1;
         we_q   <= 1'b0;
         halted <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               req_q <= 1'b0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_valid) begin
                  if (mem_rdata == HALT_INSTR) begin
                     halted <= 1'b1;
                     state  <= ST_HALT;
                  end else begin
                     ir    <= mem_rdata;
                     we_q  <= ~mem_rdata[J_BIT] & ~mem_rdata[B_BIT];
                     state <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               pc_q  <= next_pc;
               we_q  <= 1'b0;
               req_q <= 1'b1;
               state <= ST_FETCH;
            end
            default: begin
               req_q <= 1'b0;
               we_q  <= 1'b0;
               state <= ST_HALT;
            end
         endcase
      end
   end

   // rst overrides on the same edge, so request and write never leak out
   // of a reset cycle even while the flops still hold their old values.
   assign mem_req  = req_q & ~rst;
   assign we_rf    = we_q & ~rst;
   assign mem_addr = pc_q;
   assign PC       = pc_q;

   assign Upr_ALU = ir[ALU_HI:ALU_LO];
   assign WS      = ir[WS_HI:WS_LO];
   assign RA1     = ir[RA1_HI:RA1_LO];
   assign RA2     = ir[RA2_HI:RA2_LO];
   assign WA      = ir[WA_HI:WA_LO];
   assign Const   = {{(32-(CONST_HI-CONST_LO+1)){ir[CONST_HI]}}, ir[CONST_HI:CONST_LO]};

endmodule

// File: tb/tb_cobra_fetch_ctrl.sv
// Bench for cobra_fetch_ctrl: directed and random instruction streams checked
// against an arithmetic model of PC flow and field decode.
module tb_cobra_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   logic        mem_valid = 1'b0;
   logic [3:0]  upr_alu;
   logic [1:0]  ws;
   logic [4:0]  ra1, ra2, wa;
   logic [31:0] cnst;
   logic        we_rf;
   logic        c_flag = 1'b0;
   logic [31:0] pc;
   logic        halted;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] mpc;
   logic [31:0] prev_ir;

   cobra_fetch_ctrl #(.RESET_PC(RST_PC), .OFFSET_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .Upr_ALU   (upr_alu),
      .WS        (ws),
      .RA1       (ra1),
      .RA2       (ra2),
      .WA        (wa),
      .Const     (cnst),
      .we_rf     (we_rf),
      .C         (c_flag),
      .PC        (pc),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_const(input logic [31:0] w);
      int v;
      v = int'(w[27:5]);
      if (w[27]) v = v - (1 << 23);
      return 32'(v);
   endfunction

   function automatic logic [31:0] exp_next(input logic [31:0] cur, input logic [31:0] w,
                                            input bit c);
      int off;
      off = int'(w[12:5]);
      if (off > 127) off = off - 256;
      if (w[31] || (w[30] && c)) return cur + 32'(off * 4);
      return cur + 32'd4;
   endfunction

   function automatic logic [31:0] mk(input bit j, input bit b, input logic [7:0] off,
                                      input logic [3:0] alu);
      return {j, b, 2'b01, 1'b0, alu, 5'd3, 5'd7, off, 5'd9};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_fields(input string tag, input logic [31:0] w);
      chk({tag, "_alu"},   32'(upr_alu), 32'(w[26:23]));
      chk({tag, "_const"}, cnst, exp_const(w));
      chk({tag, "_ra1"},   32'(ra1), 32'(w[22:18]));
      chk({tag, "_ra2"},   32'(ra2), 32'(w[17:13]));
      chk({tag, "_wa"},    32'(wa),  32'(w[4:0]));
      chk({tag, "_ws"},    32'(ws),  32'(w[29:28]));
   endtask

   task automatic do_reset();
      mem_valid = 1'b0;
      rst = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_req",    32'(mem_req), 32'd0);
      chk("rst_we",     32'(we_rf),   32'd0);
      chk("rst_halted", 32'(halted),  32'd0);
      chk("rst_pc",     pc,           RST_PC);
      check_fields("rst", 32'd0);
      next_cycle();
      rst     = 1'b0;
      mpc     = RST_PC;
      prev_ir = '0;
   endtask

   // Entered at the start of a FETCH cycle; returns at the start of the next
   // FETCH cycle (or in the HALT cycle for the halt word).
   task automatic run_instr(input logic [31:0] w, input int lat, input bit c,
                            input bit spur, input bit abort);
      logic [31:0] nxt;
      mem_valid = spur;
      mem_rdata = $urandom;
      @(negedge clk);
      chk("fetch_req",    32'(mem_req), 32'd1);
      chk("fetch_addr",   mem_addr,     mpc);
      chk("fetch_we",     32'(we_rf),   32'd0);
      chk("fetch_halted", 32'(halted),  32'd0);
      chk("fetch_ir_hold", 32'(upr_alu), 32'(prev_ir[26:23]));
      for (int i = 1; i <= lat; i++) begin
         next_cycle();
         mem_valid = (i == lat);
         mem_rdata = (i == lat) ? w : $urandom;
         @(negedge clk);
         chk("wait_req", 32'(mem_req), 32'd0);
         chk("wait_we",  32'(we_rf),   32'd0);
         if (i == 1) check_fields("wait_hold", prev_ir);
      end
      next_cycle();
      mem_valid = spur;
      mem_rdata = $urandom;
      c_flag    = c;
      if (w == HALT_W) begin
         @(negedge clk);
         chk("halt_flag", 32'(halted),  32'd1);
         chk("halt_pc",   pc,           mpc);
         chk("halt_req",  32'(mem_req), 32'd0);
         chk("halt_we",   32'(we_rf),   32'd0);
         return;
      end
      if (abort) rst = 1'b1;
      @(negedge clk);
      chk("exec_we",  32'(we_rf),   (abort || w[31] || w[30]) ? 32'd0 : 32'd1);
      chk("exec_req", 32'(mem_req), 32'd0);
      chk("exec_pc",  pc,           mpc);
      check_fields("exec", w);
      nxt = exp_next(mpc, w, c);
      next_cycle();
      mem_valid = 1'b0;
      c_flag    = $urandom_range(0, 1);
      if (abort) begin
         rst     = 1'b0;
         mpc     = RST_PC;
         prev_ir = '0;
      end else begin
         mpc     = nxt;
         prev_ir = w;
      end
   endtask

   task automatic abort_wait();
      @(negedge clk);
      chk("aw_req", 32'(mem_req), 32'd1);
      next_cycle();
      mem_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("aw_we",  32'(we_rf),   32'd0);
      chk("aw_req", 32'(mem_req), 32'd0);
      next_cycle();
      rst     = 1'b0;
      mpc     = RST_PC;
      prev_ir = '0;
   endtask

   initial begin
      logic [31:0] w;
      do_reset();

      run_instr(mk(0, 0, 8'd0,   4'd0),  1, 1'b0, 1'b0, 1'b0);  // 0x00 -> 0x04
      run_instr(mk(1, 0, 8'd3,   4'd1),  1, 1'b0, 1'b0, 1'b0);  // 0x04 -> 0x10
      run_instr(mk(0, 1, 8'hFE,  4'd10), 1, 1'b1, 1'b0, 1'b0);  // 0x10 -> 0x08
      run_instr(mk(1, 0, 8'd2,   4'd2),  2, 1'b1, 1'b0, 1'b0);  // 0x08 -> 0x10
      run_instr(mk(0, 1, 8'hFE,  4'd10), 1, 1'b0, 1'b0, 1'b0);  // 0x10 -> 0x14
      run_instr(mk(1, 0, 8'd3,   4'd3),  1, 1'b1, 1'b0, 1'b0);  // 0x14 -> 0x20
      run_instr(mk(1, 0, 8'd3,   4'd4),  1, 1'b0, 1'b0, 1'b0);  // 0x20 -> 0x2C
      run_instr(mk(1, 0, 8'hF4,  4'd5),  1, 1'b0, 1'b0, 1'b0);  // 0x2C -> 0xFFFFFFFC
      run_instr(mk(0, 0, 8'd0,   4'd6),  1, 1'b0, 1'b0, 1'b0);  // wrap -> 0x0
      run_instr(mk(1, 0, 8'hFF,  4'd7),  1, 1'b0, 1'b0, 1'b0);  // 0x0 -> 0xFFFFFFFC
      run_instr(mk(1, 0, 8'd1,   4'd15), 1, 1'b1, 1'b0, 1'b0);  // wrap -> 0x0
      run_instr(mk(0, 0, 8'd0,   4'd8),  5, 1'b0, 1'b1, 1'b0);
      run_instr(mk(0, 1, 8'd4,   4'd9),  5, 1'b1, 1'b1, 1'b0);

      for (int k = 0; k < 60; k++) begin
         w = $urandom;
         if (w == HALT_W) w = 32'h1234_5678;
         run_instr(w, $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0);
      end

      abort_wait();
      run_instr(mk(0, 0, 8'd0, 4'd1), 1, 1'b0, 1'b0, 1'b0);
      run_instr(mk(1, 0, 8'd5, 4'd2), 2, 1'b1, 1'b0, 1'b1);
      run_instr(mk(0, 0, 8'd0, 4'd3), 1, 1'b0, 1'b0, 1'b0);

      do_reset();
      run_instr(mk(0, 0, 8'd0, 4'd0), 1, 1'b0, 1'b0, 1'b0);
      run_instr(mk(0, 0, 8'd0, 4'd1), 3, 1'b0, 1'b0, 1'b0);
      run_instr(HALT_W, 2, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         next_cycle();
         mem_valid = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         @(negedge clk);
         chk("hold_req",    32'(mem_req), 32'd0);
         chk("hold_halted", 32'(halted),  32'd1);
         chk("hold_pc",     pc,           32'h8);
         chk("hold_ir",     32'(upr_alu), 32'(prev_ir[26:23]));
      end
      do_reset();
      run_instr(mk(0, 0, 8'd0, 4'd11), 1, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
